sipo_word_loader: RTL and testbench
===================================

Name: sipo_word_loader

Overview:
- Serial-in/parallel-out assembler that sits directly upstream of the team's enabled parallel register.
- Collects WIDTH serial bits per frame, then presents the assembled word with a one-cycle load strobe.
- Downstream wiring: word_out drives the register's d_in; load_en drives the register's en.
- Lets a serial source update the register only on complete, valid frames.

Parameters:
- WIDTH, 3: bits per frame; width of word_out (min 2).
- MSB_FIRST, 1: 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- start  input  1  frame start pulse; carries no data.
- ser_in  input  1  serial data bit, sampled only when bit_vld=1.
- bit_vld  input  1  ser_in is valid this cycle.
- word_out  output  WIDTH  last completed word, registered.
- load_en  output  1  one-cycle strobe: word_out is new this cycle.
- busy  output  1  high while a frame is in progress.
- parity_err  output  1  one-cycle error pulse; constant 0 unless PARITY_CHECK_EN is defined.

Behaviour:
- Reset (reset=0, async): state=IDLE, bit counter=0, shift register=0, word_out=0, load_en=0, busy=0, parity_err=0.
- States: IDLE, SHIFT, and PAR (PAR exists only with PARITY_CHECK_EN).
- IDLE:
  - busy=0; ser_in and bit_vld are ignored.
  - start=1 → SHIFT, counter=0, shift register cleared.
  - A bit_vld in the start cycle is discarded.
- SHIFT:
  - busy=1.
  - Each cycle with bit_vld=1: shift ser_in in (left-shift if MSB_FIRST=1, right-shift if 0); counter+1.
  - bit_vld=0 holds all state; gaps of any length are allowed.
- Frame completion (bit_vld=1 while counter==WIDTH-1):
  - On that edge, word_out ← shift register with the final bit included; load_en=1 for the following cycle only.
  - FSM → IDLE; counter returns to 0.
  - Latency: load_en is high in the cycle immediately after the last data bit is sampled.
- start=1 while in SHIFT:
  - Aborts the current frame, clears counter and shift register, stays in SHIFT.
  - start wins over a simultaneous final bit: no load_en, word_out unchanged.
- start=1 in the cycle load_en is high:
  - Accepted normally from IDLE, so back-to-back frames lose no cycle.
- Output holding:
  - word_out holds its value between loads and changes only on a completed frame.
  - load_en is never high for two consecutive cycles.
- Counter: width clog2(WIDTH); wraps to 0 only via completion, abort, or reset. It never passes WIDTH-1.
- Reset asserted mid-frame: partial frame is discarded, all outputs return to reset values immediately, and no load_en is produced.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - After the WIDTH data bits, FSM enters PAR and waits for one more bit_vld bit: an even-parity bit (XOR of data bits).
  - Match: word_out updated, load_en pulse (latency measured from the parity bit), FSM → IDLE.
  - Mismatch: word_out unchanged, no load_en, parity_err=1 for one cycle, FSM → IDLE.
  - start in PAR aborts exactly as in SHIFT.
- Not defined: no PAR state, parity_err tied to 0, completion exactly as above.

Decomposition:
- Shared package dld_pkg:
  - state enum (IDLE, SHIFT, PAR).
  - default WIDTH constant.
  - counter-width helper function.
- One natural sub-module, bit_counter:
  - Parameterised up-counter with clear, enable, and terminal-count flag (count==LIMIT-1).
  - Same async active-low reset as the parent.
  - Instantiated once for the frame bit count.
- Shifting and the FSM stay in the top module.

Test Plan:
- MSB_FIRST=1, WIDTH=3: start, then bits 1,1,0 on consecutive cycles → word_out=3'b110, load_en high exactly 1 cycle after the third bit, busy low after.
- MSB_FIRST=0: start, bits 1,1,0 → word_out=3'b011; same for 1,0,0 → 3'b001.
- MSB_FIRST=1 with gaps: start, bit 1, 3 idle cycles, bit 0, 1 idle cycle, bit 1 → word_out=3'b101 with a single load_en. Then a second frame started in the load_en cycle with bits 0,1,1 → word_out=3'b011.
- Abort: start, bits 1,1, start, bits 0,0,1 → only one load_en, word_out=3'b001. Start coinciding with the final bit → no load_en, previous word_out held.
- Reset: drop reset low after 2 bits of a frame → word_out=0, busy=0, load_en=0 asynchronously; after release, a full frame 1,0,1 loads 3'b101.
- PARITY_CHECK_EN: bits 1,1,0 + parity 0 → word_out=3'b110, load_en. Bits 1,1,1 + parity 0 → parity_err 1-cycle pulse, no load_en, word_out stays 3'b110.

Source files
------------

// File: rtl/dld_pkg.sv
// Shared types and helpers for the serial-in/parallel-out word loader.
// Holds the FSM state enum, default frame width and counter-width helper.
package dld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_word_loader_if.sv
// Serial source / word sink bundle for sipo_word_loader.
// master: drives start, ser_in, bit_vld; slave: drives word_out, load_en, busy, parity_err.
interface sipo_word_loader_if
  import dld_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             ser_in;
  logic             bit_vld;
  logic [WIDTH-1:0] word_out;
  logic             load_en;
  logic             busy;
  logic             parity_err;

  modport master (
    output start, ser_in, bit_vld,
    input  word_out, load_en, busy, parity_err
  );

  modport slave (
    input  start, ser_in, bit_vld,
    output word_out, load_en, busy, parity_err
  );

endinterface

// File: rtl/sipo_word_loader_bit_counter.sv
// bit_counter: up-counter with clear, enable and terminal-count flag.
// Ports: i_clk, i_rst_n (async low), i_clr, i_en, o_tc (count == LIMIT-1).
module bit_counter #(
  parameter int LIMIT = 3,
  parameter int CW    = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc = (r_count == CW'(LIMIT - 1));
  assign o_tc = w_tc;

  // Clear beats enable; the terminal count wraps straight back to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_word_loader.sv
// Assembles WIDTH serial bits into a word and strobes load_en for one cycle.
// Ports: clk, reset (async low), bus (slave modport). Option: PARITY_CHECK_EN.
module sipo_word_loader
  import dld_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  sipo_word_loader_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_load;
  logic             r_busy;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_tc;
  logic             w_cnt_en;

  always_comb begin
    w_shift_nxt = r_shift;
    if (MSB_FIRST) begin
      w_shift_nxt = {r_shift[WIDTH-2:0], bus.ser_in};
    end else begin
      w_shift_nxt = {bus.ser_in, r_shift[WIDTH-1:1]};
    end
  end

  assign w_cnt_en = (r_state == SHIFT)
                  & bus.bit_vld & ~bus.start;

  bit_counter #(
    .LIMIT (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (bus.start),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

`ifdef PARITY_CHECK_EN
  logic r_perr;
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.word_out = r_word;
  assign bus.load_en  = r_load;
  assign bus.busy     = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_word  <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_load <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SHIFT;
            r_shift <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // A restart outranks a simultaneous final bit.
          if (bus.start) begin
            r_shift <= '0;
          end else if (bus.bit_vld) begin
            r_shift <= w_shift_nxt;
            if (w_tc) begin
`ifdef PARITY_CHECK_EN
              r_state <= PAR;
`else
              r_word  <= w_shift_nxt;
              r_load  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          if (bus.start) begin
            r_shift <= '0;
            r_state <= SHIFT;
          end else if (bus.bit_vld) begin
            // Even parity: the extra bit equals the XOR of the data bits.
            if (bus.ser_in == ^r_shift) begin
              r_word <= r_shift;
              r_load <= 1'b1;
            end else begin
              r_perr <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_word_loader.sv
// Directed bench for sipo_word_loader, MSB-first and LSB-first in lockstep.
// Build with +define+PARITY_CHECK_EN to exercise the parity option.
module tb_sipo_word_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ser_in;
  logic bit_vld;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       st;
    logic       vld;
    logic       ser;
    logic       load;
    logic       busy;
    logic [2:0] wm;
    logic [2:0] wl;
  } vec_t;

  vec_t vq[$];

  sipo_word_loader_if #(.WIDTH(3)) if_m ();
  sipo_word_loader_if #(.WIDTH(3)) if_l ();

  assign if_m.start   = start;
  assign if_m.ser_in  = ser_in;
  assign if_m.bit_vld = bit_vld;
  assign if_l.start   = start;
  assign if_l.ser_in  = ser_in;
  assign if_l.bit_vld = bit_vld;

  sipo_word_loader #(
    .WIDTH     (3),
    .MSB_FIRST (1'b1)
  ) u_msb (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_m.slave)
  );

  sipo_word_loader #(
    .WIDTH     (3),
    .MSB_FIRST (1'b0)
  ) u_lsb (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_l.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic ld,
                         input logic bz,
                         input logic [2:0] wm,
                         input logic [2:0] wl,
                         input logic pe);
    chk({nm, " load_m"}, 8'(if_m.load_en), 8'(ld));
    chk({nm, " load_l"}, 8'(if_l.load_en), 8'(ld));
    chk({nm, " busy"}, 8'(if_m.busy), 8'(bz));
    chk({nm, " word_m"}, 8'(if_m.word_out), 8'(wm));
    chk({nm, " word_l"}, 8'(if_l.word_out), 8'(wl));
    chk({nm, " perr"}, 8'(if_m.parity_err), 8'(pe));
  endtask

  task automatic step(input logic s,
                      input logic v,
                      input logic d);
    @(negedge clk);
    start   = s;
    bit_vld = v;
    ser_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic s, v, d,
                      input logic ld, bz,
                      input logic [2:0] wm, wl);
    vec_t x;
    x.st = s; x.vld = v; x.ser = d;
    x.load = ld; x.busy = bz;
    x.wm = wm; x.wl = wl;
    vq.push_back(x);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ser_in  = 1'b0;
    bit_vld = 1'b0;

`ifndef PARITY_CHECK_EN
    // s v d | load busy wm wl
    addv(1,0,0, 0,1, 3'd0,3'd0);
    addv(0,1,1, 0,1, 3'd0,3'd0);
    addv(0,1,1, 0,1, 3'd0,3'd0);
    addv(0,1,0, 1,0, 3'd6,3'd3);
    addv(0,0,0, 0,0, 3'd6,3'd3);
    addv(1,0,0, 0,1, 3'd6,3'd3);
    addv(0,1,1, 0,1, 3'd6,3'd3);
    addv(0,1,0, 0,1, 3'd6,3'd3);
    addv(0,1,0, 1,0, 3'd4,3'd1);
    // gaps; bit_vld on the start cycle is dropped
    addv(1,1,0, 0,1, 3'd4,3'd1);
    addv(0,1,1, 0,1, 3'd4,3'd1);
    addv(0,0,0, 0,1, 3'd4,3'd1);
    addv(0,0,0, 0,1, 3'd4,3'd1);
    addv(0,0,0, 0,1, 3'd4,3'd1);
    addv(0,1,0, 0,1, 3'd4,3'd1);
    addv(0,0,1, 0,1, 3'd4,3'd1);
    addv(0,1,1, 1,0, 3'd5,3'd5);
    // start during the load_en cycle
    addv(1,0,0, 0,1, 3'd5,3'd5);
    addv(0,1,0, 0,1, 3'd5,3'd5);
    addv(0,1,1, 0,1, 3'd5,3'd5);
    addv(0,1,1, 1,0, 3'd3,3'd6);
    // abort after two bits
    addv(1,0,0, 0,1, 3'd3,3'd6);
    addv(0,1,1, 0,1, 3'd3,3'd6);
    addv(0,1,1, 0,1, 3'd3,3'd6);
    addv(1,0,0, 0,1, 3'd3,3'd6);
    addv(0,1,0, 0,1, 3'd3,3'd6);
    addv(0,1,0, 0,1, 3'd3,3'd6);
    addv(0,1,1, 1,0, 3'd1,3'd4);
    // start on the final bit wins
    addv(0,0,0, 0,0, 3'd1,3'd4);
    addv(1,0,0, 0,1, 3'd1,3'd4);
    addv(0,1,1, 0,1, 3'd1,3'd4);
    addv(0,1,0, 0,1, 3'd1,3'd4);
    addv(1,1,1, 0,1, 3'd1,3'd4);
    addv(0,0,0, 0,1, 3'd1,3'd4);
    addv(0,1,1, 0,1, 3'd1,3'd4);
    addv(0,1,1, 0,1, 3'd1,3'd4);
    addv(0,1,1, 1,0, 3'd7,3'd7);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].st, vq[i].vld, vq[i].ser);
      chk_all($sformatf("v%0d", i),
              vq[i].load, vq[i].busy,
              vq[i].wm, vq[i].wl, 1'b0);
    end

`ifdef PARITY_CHECK_EN
    step(1,0,0);
    step(0,1,1);
    step(0,1,1);
    step(0,1,0);
    chk_all("par_wait", 0, 1, 3'd0, 3'd0, 0);
    step(0,1,0);
    chk_all("par_ok", 1, 0, 3'd6, 3'd3, 0);
    step(1,0,0);
    step(0,1,1);
    step(0,1,1);
    step(0,1,1);
    step(0,1,0);
    chk_all("par_bad", 0, 0, 3'd6, 3'd3, 1);
    step(0,0,0);
    chk_all("par_after", 0, 0, 3'd6, 3'd3, 0);
`endif

    // mid-frame asynchronous reset
    step(1,0,0);
    step(0,1,1);
    step(0,1,0);
    @(negedge clk);
    bit_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 3'd0, 3'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1,0,0);
    step(0,1,1);
    step(0,1,0);
    step(0,1,1);
`ifdef PARITY_CHECK_EN
    chk_all("post_data", 0, 1, 3'd0, 3'd0, 0);
    step(0,1,0);
`endif
    chk_all("post_rst", 1, 0, 3'd5, 3'd5, 0);
    step(0,0,0);
    chk_all("post_idle", 0, 0, 3'd5, 3'd5, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
